// File: rtl/fifo_status_flags_if.sv
// Request/status bundle between the FIFO front end and its occupancy tracker.
//   master : drives write_en, read_en, thr_load, ae_thr_in, af_thr_in, clr_err
//   slave  : drives pointers, count, accept strobes, status and error flags
interface fifo_status_flags_if #(
    parameter int unsigned SIZE = 4
);
    logic              write_en;
    logic              read_en;
    logic              thr_load;
    logic [SIZE-1:0]   ae_thr_in;
    logic [SIZE-1:0]   af_thr_in;
    logic              clr_err;

    logic [SIZE-1:0]   write_pointer;
    logic [SIZE-1:0]   read_pointer;
    logic [SIZE:0]     count;
    logic              write_accept;
    logic              read_accept;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    modport master (
        output write_en, read_en, thr_load, ae_thr_in, af_thr_in, clr_err,
        input  write_pointer, read_pointer, count, write_accept, read_accept,
               empty, full, almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  write_en, read_en, thr_load, ae_thr_in, af_thr_in, clr_err,
        output write_pointer, read_pointer, count, write_accept, read_accept,
               empty, full, almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/fifo_status_flags.sv
// Occupancy tracker and status-flag generator for a synchronous FIFO.
// Owns the read/write pointers and occupancy count, and drives registered
// empty/full/almost-empty/almost-full flags against run-time programmable
// thresholds, plus sticky overflow/underflow error flags.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of fifo_status_flags_if (requests in, status out)
module fifo_status_flags #(
    parameter int unsigned SIZE                 = 4,
    parameter int unsigned ALMOST_EMPTY_DEFAULT = 2,
    parameter int unsigned ALMOST_FULL_DEFAULT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    fifo_status_flags_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** SIZE;
    localparam int unsigned CW    = SIZE + 1;

    logic [SIZE-1:0] r_wr_ptr;
    logic [SIZE-1:0] r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_empty;
    logic            r_full;
    logic            r_almost_empty;
    logic            r_almost_full;
    logic            r_overflow;
    logic            r_underflow;
    logic [SIZE-1:0] r_ae_thr;
    logic [SIZE-1:0] r_af_thr;

    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [CW-1:0]   w_next_count;
    logic [SIZE-1:0] w_next_ae_thr;
    logic [SIZE-1:0] w_next_af_thr;
    logic [CW-1:0]   w_af_level;

    // Accepts use only the registered flags, so no request reaches a flag combinationally.
    assign w_wr_acc = bus.write_en & ~r_full;
    assign w_rd_acc = bus.read_en  & ~r_empty;

    // Next-state occupancy and thresholds; flags are computed from these so a
    // threshold load is visible on the same edge.
    always_comb begin
        w_next_count  = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
        w_next_ae_thr = bus.thr_load ? bus.ae_thr_in : r_ae_thr;
        w_next_af_thr = bus.thr_load ? bus.af_thr_in : r_af_thr;
        w_af_level    = CW'(DEPTH) - CW'(w_next_af_thr);
    end

    // State and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_ae_thr       <= SIZE'(ALMOST_EMPTY_DEFAULT);
            r_af_thr       <= SIZE'(ALMOST_FULL_DEFAULT);
        end else begin
            r_wr_ptr       <= r_wr_ptr + SIZE'(w_wr_acc);
            r_rd_ptr       <= r_rd_ptr + SIZE'(w_rd_acc);
            r_count        <= w_next_count;
            r_empty        <= (w_next_count == '0);
            r_full         <= (w_next_count == CW'(DEPTH));
            r_almost_empty <= (w_next_count <= CW'(w_next_ae_thr));
            r_almost_full  <= (w_next_count >= w_af_level);
            // Sticky errors: a new error in the clearing cycle wins.
            r_overflow     <= (bus.write_en & r_full)  | (r_overflow  & ~bus.clr_err);
            r_underflow    <= (bus.read_en  & r_empty) | (r_underflow & ~bus.clr_err);
            r_ae_thr       <= w_next_ae_thr;
            r_af_thr       <= w_next_af_thr;
        end
    end

    assign bus.write_pointer = r_wr_ptr;
    assign bus.read_pointer  = r_rd_ptr;
    assign bus.count         = r_count;
    assign bus.write_accept  = w_wr_acc;
    assign bus.read_accept   = w_rd_acc;
    assign bus.empty         = r_empty;
    assign bus.full          = r_full;
    assign bus.almost_empty  = r_almost_empty;
    assign bus.almost_full   = r_almost_full;
    assign bus.overflow      = r_overflow;
    assign bus.underflow     = r_underflow;
endmodule

// File: tb/tb_fifo_status_flags.sv
// Self-checking bench for fifo_status_flags (SIZE=4, default thresholds 2/2).
module tb_fifo_status_flags;
    localparam int SIZE  = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic reset;

    fifo_status_flags_if #(.SIZE(SIZE)) bus ();

    fifo_status_flags #(
        .SIZE                 (SIZE),
        .ALMOST_EMPTY_DEFAULT (2),
        .ALMOST_FULL_DEFAULT  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: occupancy as a plain integer, pointers as modular counters.
    int m_count, m_wp, m_rp, m_ae_thr, m_af_thr;
    bit m_ovf, m_udf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_wp     = 0;
        m_rp     = 0;
        m_ae_thr = 2;
        m_af_thr = 2;
        m_ovf    = 0;
        m_udf    = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".write_pointer"}, int'(bus.write_pointer), m_wp);
        chk({tag, ".read_pointer"},  int'(bus.read_pointer),  m_rp);
        chk({tag, ".count"},         int'(bus.count),         m_count);
        chk({tag, ".empty"},         int'(bus.empty),         int'(m_count == 0));
        chk({tag, ".full"},          int'(bus.full),          int'(m_count == DEPTH));
        chk({tag, ".almost_empty"},  int'(bus.almost_empty),  int'(m_count <= m_ae_thr));
        chk({tag, ".almost_full"},   int'(bus.almost_full),   int'(m_count >= DEPTH - m_af_thr));
        chk({tag, ".overflow"},      int'(bus.overflow),      int'(m_ovf));
        chk({tag, ".underflow"},     int'(bus.underflow),     int'(m_udf));
    endtask

    // One clock: drive, check same-cycle accepts, clock, update model, check state.
    task automatic cycle(input bit we, input bit re, input bit tl = 0, input int ae = 0,
                         input int af = 0, input bit clr = 0, input bit rst = 0);
        int wa, ra;
        bus.write_en  = we;
        bus.read_en   = re;
        bus.thr_load  = tl;
        bus.ae_thr_in = 4'(ae);
        bus.af_thr_in = 4'(af);
        bus.clr_err   = clr;
        reset         = rst;
        #1;
        wa = int'(we && (m_count != DEPTH));
        ra = int'(re && (m_count != 0));
        chk("write_accept", int'(bus.write_accept), wa);
        chk("read_accept",  int'(bus.read_accept),  ra);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m_ovf   = (we && m_count == DEPTH) || (m_ovf && !clr);
            m_udf   = (re && m_count == 0)     || (m_udf && !clr);
            m_count = m_count + wa - ra;
            m_wp    = (m_wp + wa) % DEPTH;
            m_rp    = (m_rp + ra) % DEPTH;
            if (tl) begin
                m_ae_thr = ae;
                m_af_thr = af;
            end
        end
        check_state("state");
    endtask

    typedef struct {
        bit we, re, tl, clr;
        int ae_in, af_in;
        int exp_count;
        bit exp_e, exp_f, exp_ae, exp_af, exp_ovf, exp_udf;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int wp0, rp0;
        bit we, re, tl, clr, rst;
        int wprob;

        // Vectors applied straight after reset; expectations derived by hand.
        vecs[0] = '{1,0,0,0, 0,0,  1, 0,0,1,0, 0,0};  // one write
        vecs[1] = '{1,1,0,0, 0,0,  1, 0,0,1,0, 0,0};  // both accepted
        vecs[2] = '{0,1,0,0, 0,0,  0, 1,0,1,0, 0,0};  // drain to empty
        vecs[3] = '{0,1,0,0, 0,0,  0, 1,0,1,0, 0,1};  // read while empty
        vecs[4] = '{0,0,0,1, 0,0,  0, 1,0,1,0, 0,0};  // clear error
        vecs[5] = '{0,0,1,0, 0,0,  0, 1,0,1,0, 0,0};  // thresholds 0/0
        vecs[6] = '{1,0,0,0, 0,0,  1, 0,0,0,0, 0,0};  // ae==empty now
        vecs[7] = '{0,0,1,0, 1,15, 1, 0,0,1,1, 0,0};  // ae=1, af margin 15
        vecs[8] = '{0,1,1,0, 2,2,  0, 1,0,1,0, 0,0};  // restore, drain

        model_reset();
        bus.write_en = 0; bus.read_en = 0; bus.thr_load = 0;
        bus.ae_thr_in = '0; bus.af_thr_in = '0; bus.clr_err = 0;
        reset = 1;

        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(1, 1, 1, 9, 9, 0, 1);  // reset beats requests and thr_load
        chk("reset.count", int'(bus.count), 0);
        chk("reset.empty", int'(bus.empty), 1);
        chk("reset.almost_empty", int'(bus.almost_empty), 1);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            cycle(vecs[i].we, vecs[i].re, vecs[i].tl, vecs[i].ae_in, vecs[i].af_in, vecs[i].clr);
            chk($sformatf("vec%0d.count", i),  int'(bus.count),        vecs[i].exp_count);
            chk($sformatf("vec%0d.empty", i),  int'(bus.empty),        int'(vecs[i].exp_e));
            chk($sformatf("vec%0d.full", i),   int'(bus.full),         int'(vecs[i].exp_f));
            chk($sformatf("vec%0d.ae", i),     int'(bus.almost_empty), int'(vecs[i].exp_ae));
            chk($sformatf("vec%0d.af", i),     int'(bus.almost_full),  int'(vecs[i].exp_af));
            chk($sformatf("vec%0d.ovf", i),    int'(bus.overflow),     int'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d.udf", i),    int'(bus.underflow),    int'(vecs[i].exp_udf));
        end

        // Fill from reset with 16 writes.
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 0);
            if (i == 2)  chk("fill.ae_at2", int'(bus.almost_empty), 1);
            if (i == 3)  chk("fill.ae_at3", int'(bus.almost_empty), 0);
            if (i == 13) chk("fill.af_at13", int'(bus.almost_full), 0);
            if (i == 14) chk("fill.af_at14", int'(bus.almost_full), 1);
            if (i == 15) chk("fill.full_at15", int'(bus.full), 0);
        end
        chk("fill.count", int'(bus.count), 16);
        chk("fill.full", int'(bus.full), 1);
        chk("fill.wp_wrapped", int'(bus.write_pointer), 0);

        // Write while full, then clear.
        cycle(1, 0);
        chk("ovf.set", int'(bus.overflow), 1);
        chk("ovf.count", int'(bus.count), 16);
        cycle(0, 0, 0, 0, 0, 1);
        chk("ovf.clr", int'(bus.overflow), 0);
        // Set and clear in the same cycle: set wins.
        cycle(1, 0, 0, 0, 0, 1);
        chk("ovf.set_wins", int'(bus.overflow), 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Full with both requests: read only.
        wp0 = int'(bus.write_pointer);
        rp0 = int'(bus.read_pointer);
        cycle(1, 1);
        chk("fullboth.count", int'(bus.count), 15);
        chk("fullboth.rp", int'(bus.read_pointer), (rp0 + 1) % DEPTH);
        chk("fullboth.wp", int'(bus.write_pointer), wp0);

        // Down to 5, then 20 simultaneous cycles.
        while (m_count > 5) cycle(0, 1);
        wp0 = int'(bus.write_pointer);
        rp0 = int'(bus.read_pointer);
        for (int i = 0; i < 20; i++) cycle(1, 1);
        chk("steady.count", int'(bus.count), 5);
        chk("steady.wp", int'(bus.write_pointer), (wp0 + 4) % DEPTH);
        chk("steady.rp", int'(bus.read_pointer), (rp0 + 4) % DEPTH);

        // Count 4, load ae=6 / af=0, then fill: almost_full tracks full.
        cycle(0, 1);
        chk("thr.count4", int'(bus.count), 4);
        cycle(0, 0, 1, 6, 0);
        chk("thr.ae", int'(bus.almost_empty), 1);
        while (m_count < 15) cycle(1, 0);
        chk("thr.af_at15", int'(bus.almost_full), 0);
        cycle(1, 0);
        chk("thr.af_at16", int'(bus.almost_full), 1);
        chk("thr.full_at16", int'(bus.full), 1);

        // Empty, then read-only request.
        cycle(0, 0, 1, 2, 2);
        while (m_count > 0) cycle(0, 1);
        rp0 = int'(bus.read_pointer);
        cycle(0, 1);
        chk("udf.set", int'(bus.underflow), 1);
        chk("udf.rp", int'(bus.read_pointer), rp0);

        // Reset at count 9.
        while (m_count < 9) cycle(1, 0);
        cycle(1, 1, 0, 0, 0, 0, 1);
        chk("rst9.count", int'(bus.count), 0);
        chk("rst9.wp", int'(bus.write_pointer), 0);
        chk("rst9.udf", int'(bus.underflow), 0);

        // Randomised traffic in phases biased toward filling or draining.
        for (int p = 0; p < 6; p++) begin
            wprob = (p % 2 == 0) ? 80 : 20;
            for (int i = 0; i < 80; i++) begin
                we  = ($urandom_range(0, 99) < wprob);
                re  = ($urandom_range(0, 99) < 100 - wprob);
                tl  = ($urandom_range(0, 15) == 0);
                clr = ($urandom_range(0, 7) == 0);
                rst = ($urandom_range(0, 199) == 0);
                cycle(we, re, tl, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), clr, rst);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_status_flags.md
# fifo_status_flags

Parametrised occupancy tracker and flag generator for the synchronous FIFO. It owns the read and write pointers and an occupancy counter, and drives registered full, empty, almost-empty and almost-full flags. Both almost thresholds are programmable at run time, and sticky overflow and underflow error flags are provided. It sits between the FIFO's request interface and its storage array, and supersedes the purely combinational almost-empty compare.

## Interface
**Parameters**
- SIZE, 4, pointer width; FIFO depth DEPTH = 2**SIZE entries.
- ALMOST_EMPTY_DEFAULT, 2, reset value of the almost-empty threshold (range 0..DEPTH-1).
- ALMOST_FULL_DEFAULT, 2, reset value of the almost-full margin (range 0..DEPTH-1).

**Ports**
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- write_en  in  1  write request.
- read_en  in  1  read request.
- thr_load  in  1  load ae_thr_in / af_thr_in into the threshold registers.
- ae_thr_in  in  SIZE  new almost-empty threshold.
- af_thr_in  in  SIZE  new almost-full margin.
- clr_err  in  1  clear the sticky overflow/underflow flags.
- write_pointer  out  SIZE  storage write address.
- read_pointer  out  SIZE  storage read address.
- count  out  SIZE+1  occupancy, 0..DEPTH.
- write_accept  out  1  combinational: write_en && !full.
- read_accept  out  1  combinational: read_en && !empty.
- empty, full, almost_empty, almost_full  out  1 each  registered status flags.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
**Accept rules**
- A write is accepted iff write_en && !full. A read is accepted iff read_en && !empty. Both use the current registered flags.
- An accepted write increments write_pointer modulo DEPTH. An accepted read increments read_pointer modulo DEPTH. Pointers wrap naturally from DEPTH-1 to 0.

**Counter update**
- count += write_accept - read_accept. Both accepted leaves count unchanged while both pointers advance.
- Full with both requests: the read is accepted and the write is rejected, so count becomes DEPTH-1.
- Empty with both requests: the write is accepted and the read is rejected, so count becomes 1.

**Flags (all registered, computed from next_count and next threshold values)**
- empty = (next_count == 0).
- full = (next_count == DEPTH).
- almost_empty = (next_count <= ae_thr).
- almost_full = (next_count >= DEPTH - af_thr).
- Threshold comparisons are done at width SIZE+1, unsigned. af_thr = 0 makes almost_full identical to full. ae_thr = 0 makes almost_empty identical to empty.

**Thresholds**
- On thr_load, ae_thr and af_thr capture their inputs.
- Flags reflect the new thresholds in the same edge, because they are computed from the next threshold values.

**Errors**
- overflow is set on write_en && full.
- underflow is set on read_en && empty.
- Both hold until clr_err. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0. ae_thr = ALMOST_EMPTY_DEFAULT, af_thr = ALMOST_FULL_DEFAULT.
- Reset takes priority over every other input, including in-flight requests and thr_load.
- Latency is one cycle from request to updated pointers, count and all flags. There is no combinational path from write_en/read_en to any flag.
- write_accept and read_accept are same-cycle combinational outputs. The storage array uses them as its write and read strobes.
- A rejected request changes no pointer, count or flag. Only overflow/underflow may change.

## Test plan
- Reset, then 16 writes with SIZE=4 and defaults -> count 16; full rises on the edge of write 16; almost_full rises at count 14; almost_empty falls when count reaches 3; write_pointer ends at 0 (wrapped).
- Full, then a write-only request -> write_accept 0, overflow 1, count stays 16. clr_err the next cycle -> overflow 0.
- Full, then write_en and read_en together -> count 15, full 0, read_pointer +1, write_pointer unchanged.
- Count 5, then 20 cycles of simultaneous read and write -> count stays 5; both pointers advance by 20 mod 16 = 4; no flag toggles.
- Count 4, thr_load with ae_thr_in = 6 and af_thr_in = 0 -> almost_empty 1 the next cycle; later fill to 16 -> almost_full and full rise on the same edge.
- Empty, then a read-only request -> underflow 1, read_pointer unchanged. Assert reset while count is 9 -> all outputs return to their reset values next cycle.
